// File: rtl/pcileech_tlp_rx_packer.sv
// pcileech_tlp_rx_packer: store-and-forward TRN RX to tagged 64-bit TLP words, dropping bad/oversize TLPs
module pcileech_tlp_rx_packer #(
  parameter int MAX_DW = 32,
  parameter int CNT_W = 6
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] trn_rd,
  input  logic        trn_rsof_n,
  input  logic        trn_reof_n,
  input  logic        trn_rsrc_rdy_n,
  input  logic        trn_rsrc_dsc_n,
  input  logic        trn_rerrfwd_n,
  output logic        trn_rdst_rdy_n,
  input  logic        cfg_bus_master_en,
  output logic [63:0] tlp_tx_data,
  output logic        tlp_tx_valid,
  input  logic        tlp_tx_ready,
  output logic [15:0] stat_drop_cnt
);
  localparam int AW = $clog2(MAX_DW);
  typedef enum logic [1:0] {IDLE, FILL, DROP, DRAIN} state_t;
  state_t state, state_n;
  logic [31:0] mem [MAX_DW];
  logic [CNT_W-1:0] cnt, cnt_n, len, len_n, rd, rd_n;
  logic [AW-1:0] wa;
  logic [1:0] ndrop;
  logic [16:0] drop_sum;
  logic bme, bme_n, err, err_n, we;
  logic acc, sof, eof, dsc, ef, last, xfer, start;
  assign acc = ~trn_rsrc_rdy_n & ~trn_rdst_rdy_n;
  assign sof = ~trn_rsof_n;
  assign eof = ~trn_reof_n;
  assign dsc = ~trn_rsrc_dsc_n;
  assign ef = ~trn_rerrfwd_n;
  assign last = rd == len - 1'b1;
  assign tlp_tx_valid = state == DRAIN;
  assign tlp_tx_data = tlp_tx_valid ? {mem[rd[AW-1:0]], 20'h0, bme, last, 2'b11, 8'h77} : 64'h0;
  assign xfer = tlp_tx_valid & tlp_tx_ready;
  // a sof beat (re)starts a TLP from IDLE, or from FILL where it aborts the partial one
  assign start = acc & sof & ~dsc & (state == IDLE | state == FILL);
  assign drop_sum = {1'b0, stat_drop_cnt} + 17'(ndrop);
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    len_n = len;
    rd_n = rd;
    bme_n = bme;
    err_n = err;
    we = 1'b0;
    wa = cnt[AW-1:0];
    ndrop = 2'd0;
    case (state)
      IDLE: ndrop = (acc & sof & dsc) ? 2'd1 : 2'd0;
      FILL: if (acc) begin
        if (dsc | sof) begin
          ndrop = 2'd1;
          state_n = IDLE;
        end else if (cnt == CNT_W'(MAX_DW)) begin
          ndrop = eof ? 2'd1 : 2'd0;
          state_n = eof ? IDLE : DROP;
        end else begin
          we = 1'b1;
          cnt_n = cnt + 1'b1;
          err_n = err | ef;
          if (eof) begin
            len_n = cnt + 1'b1;
            rd_n = '0;
            ndrop = (err | ef) ? 2'd1 : 2'd0;
            state_n = (err | ef) ? IDLE : DRAIN;
          end
        end
      end
      DROP: if (acc & (eof | dsc)) begin
        ndrop = 2'd1;
        state_n = IDLE;
      end
      DRAIN: if (xfer) begin
        rd_n = rd + 1'b1;
        state_n = last ? IDLE : DRAIN;
      end
      default: state_n = IDLE;
    endcase
    if (start) begin
      we = 1'b1;
      wa = '0;
      cnt_n = CNT_W'(1);
      len_n = CNT_W'(1);
      rd_n = '0;
      bme_n = cfg_bus_master_en;
      err_n = ef;
      state_n = ~eof ? FILL : ef ? IDLE : DRAIN;
      ndrop = ndrop + ((eof & ef) ? 2'd1 : 2'd0);
    end
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      cnt <= '0;
      len <= '0;
      rd <= '0;
      bme <= 1'b0;
      err <= 1'b0;
      trn_rdst_rdy_n <= 1'b1;
      stat_drop_cnt <= 16'h0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      len <= len_n;
      rd <= rd_n;
      bme <= bme_n;
      err <= err_n;
      trn_rdst_rdy_n <= state_n == DRAIN;
      stat_drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end
  always_ff @(posedge CLK) if (we) mem[wa] <= trn_rd;
endmodule

// File: tb/tb_pcileech_tlp_rx_packer.sv
// tb_pcileech_tlp_rx_packer: directed TLPs with a queue scoreboard checked by a negedge monitor
module tb_pcileech_tlp_rx_packer;
  logic CLK = 1'b0, RESET = 1'b1;
  logic [31:0] trn_rd = '0;
  logic trn_rsof_n = 1'b1, trn_reof_n = 1'b1, trn_rsrc_rdy_n = 1'b1;
  logic trn_rsrc_dsc_n = 1'b1, trn_rerrfwd_n = 1'b1, cfg_bus_master_en = 1'b0;
  logic tlp_tx_ready = 1'b1;
  logic trn_rdst_rdy_n, tlp_tx_valid;
  logic [63:0] tlp_tx_data;
  logic [15:0] stat_drop_cnt;
  logic [63:0] q[$];
  logic [63:0] stall_data;
  logic stall_prev = 1'b0;
  bit tog = 1'b0;
  int tests = 0, fails = 0, exp_drop = 0;
  pcileech_tlp_rx_packer dut (
    .CLK(CLK), .RESET(RESET), .trn_rd(trn_rd), .trn_rsof_n(trn_rsof_n), .trn_reof_n(trn_reof_n),
    .trn_rsrc_rdy_n(trn_rsrc_rdy_n), .trn_rsrc_dsc_n(trn_rsrc_dsc_n), .trn_rerrfwd_n(trn_rerrfwd_n),
    .trn_rdst_rdy_n(trn_rdst_rdy_n), .cfg_bus_master_en(cfg_bus_master_en), .tlp_tx_data(tlp_tx_data),
    .tlp_tx_valid(tlp_tx_valid), .tlp_tx_ready(tlp_tx_ready), .stat_drop_cnt(stat_drop_cnt)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  always @(posedge CLK) if (tog) begin
    #1;
    tlp_tx_ready = ~tlp_tx_ready;
  end
  always @(negedge CLK) begin
    if (RESET) stall_prev = 1'b0;
    else begin
      if (stall_prev) chk("stall_hold", {63'h0, tlp_tx_valid} ^ tlp_tx_data, 64'h1 ^ stall_data);
      if (tlp_tx_valid) chk("dst_rdy_n_drain", 64'(trn_rdst_rdy_n), 64'h1);
      else chk("data_zero_idle", tlp_tx_data, 64'h0);
      if (tlp_tx_valid && tlp_tx_ready) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got %h expected none", tlp_tx_data);
        end else chk("out_word", tlp_tx_data, q.pop_front());
      end
      stall_prev = tlp_tx_valid & ~tlp_tx_ready;
      stall_data = tlp_tx_data;
    end
  end
  task automatic send(input int n, input logic [31:0] base, input logic b, input int dsc_at,
                      input int err_at, input bit model);
    for (int i = 0; i < n && model; i++)
      q.push_back({base + 32'(i), 20'h0, b, i == n - 1, 2'b11, 8'h77});
    cfg_bus_master_en = b;
    for (int i = 0; i < n; i++) begin
      int t = 0;
      while (trn_rdst_rdy_n && t < 2000) begin
        @(posedge CLK);
        #1;
        t++;
      end
      if (t >= 2000) chk("dst_rdy_timeout", 64'(trn_rdst_rdy_n), 64'h0);
      trn_rd = base + 32'(i);
      trn_rsof_n = i != 0;
      trn_reof_n = i != n - 1;
      trn_rsrc_dsc_n = i != dsc_at;
      trn_rerrfwd_n = i != err_at;
      trn_rsrc_rdy_n = 1'b0;
      @(posedge CLK);
      #1;
      if (i == dsc_at) break;
    end
    {trn_rsrc_rdy_n, trn_rsof_n, trn_reof_n, trn_rsrc_dsc_n, trn_rerrfwd_n} = 5'h1F;
  endtask
  task automatic wait_empty(input string nm);
    int t = 0;
    while ((q.size() != 0 || tlp_tx_valid) && t < 5000) begin
      @(posedge CLK);
      #1;
      t++;
    end
    chk(nm, 64'(q.size()), 64'h0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_dst_rdy_n", 64'(trn_rdst_rdy_n), 64'h1);
    chk("rst_valid", 64'(tlp_tx_valid), 64'h0);
    chk("rst_data", tlp_tx_data, 64'h0);
    chk("rst_drop_cnt", 64'(stat_drop_cnt), 64'h0);
    RESET = 1'b0;
    @(posedge CLK);
    #1;
    chk("dst_rdy_after_rst", 64'(trn_rdst_rdy_n), 64'h0);
    trn_rd = 32'hDEAD;
    trn_rsrc_rdy_n = 1'b0;
    @(posedge CLK);
    #1;
    trn_rsrc_rdy_n = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    q.push_back(64'h000000A0_00000B77);
    q.push_back(64'h000000A1_00000B77);
    q.push_back(64'h000000A2_00000B77);
    q.push_back(64'h000000A3_00000F77);
    send(4, 32'hA0, 1'b1, -1, -1, 1'b0);
    n = 0;
    @(negedge CLK);
    while (tlp_tx_valid && n < 100) begin
      n++;
      @(negedge CLK);
    end
    chk("t1_consecutive", 64'(n), 64'd4);
    wait_empty("t1_drained");
    q.push_back(64'h000000A0_00000377);
    q.push_back(64'h000000A1_00000377);
    q.push_back(64'h000000A2_00000377);
    q.push_back(64'h000000A3_00000777);
    tog = 1'b1;
    send(4, 32'hA0, 1'b0, -1, -1, 1'b0);
    wait_empty("t2_drained");
    tog = 1'b0;
    @(posedge CLK);
    #2;
    tlp_tx_ready = 1'b1;
    send(33, 32'h1000, 1'b1, -1, -1, 1'b0);
    exp_drop++;
    send(3, 32'hB0, 1'b1, -1, -1, 1'b1);
    wait_empty("t3_drained");
    chk("t3_drop_cnt", 64'(stat_drop_cnt), 64'(exp_drop));
    send(5, 32'hC0, 1'b1, 2, -1, 1'b0);
    exp_drop++;
    send(4, 32'hD0, 1'b1, -1, 1, 1'b0);
    exp_drop++;
    send(2, 32'hE0, 1'b1, -1, -1, 1'b1);
    wait_empty("t4_drained");
    chk("t4_drop_cnt", 64'(stat_drop_cnt), 64'(exp_drop));
    send(32, 32'h2000, 1'b1, -1, -1, 1'b1);
    wait_empty("t5_drained");
    chk("t5_drop_cnt", 64'(stat_drop_cnt), 64'(exp_drop));
    tlp_tx_ready = 1'b0;
    send(4, 32'h300, 1'b1, -1, -1, 1'b1);
    tlp_tx_ready = 1'b1;
    @(posedge CLK);
    #1;
    tlp_tx_ready = 1'b0;
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    chk("t6_valid_after_rst", 64'(tlp_tx_valid), 64'h0);
    chk("t6_data_after_rst", tlp_tx_data, 64'h0);
    chk("t6_dst_rdy_in_rst", 64'(trn_rdst_rdy_n), 64'h1);
    chk("t6_words_left", 64'(q.size()), 64'd3);
    q.delete();
    exp_drop = 0;
    RESET = 1'b0;
    @(posedge CLK);
    #1;
    chk("t6_dst_rdy_after_rst", 64'(trn_rdst_rdy_n), 64'h0);
    chk("t6_drop_cnt", 64'(stat_drop_cnt), 64'h0);
    tlp_tx_ready = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    send(3, 32'hF0, 1'b0, -1, -1, 1'b1);
    wait_empty("t6_next_tlp");
    repeat (4) @(posedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
